// File: rtl/serializer_param.sv
// serializer_param
//   Parallel-to-serial converter with a variable word length and a one-entry
//   pending buffer, so that back-to-back words come out with no gap.
//
// Parameters
//   DATA_W    parallel word width (power of two, >= 4)
//   MOD_W     width of data_mod_i
//   MIN_LEN   shortest accepted word length in bits
//   MSB_FIRST 1: word is MSB-aligned and sent MSB first; 0: LSB-aligned, LSB first
//
// Ports
//   clk_i          clock, rising edge
//   arst_n_i       asynchronous active-low reset
//   data_i         parallel word
//   data_mod_i     word length, 0 means DATA_W bits
//   data_val_i     data_i / data_mod_i valid
//   ready_o        a word can be accepted this cycle
//   ser_data_o     serial bit (0 when not valid)
//   ser_data_val_o serial bit valid
//   busy_o         a word is shifting or pending
//   drop_o         one-cycle pulse after a too-short word was presented
module serializer_param #(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned MOD_W     = $clog2(DATA_W),
    parameter int unsigned MIN_LEN   = 3,
    parameter int unsigned MSB_FIRST = 1
) (
    input  logic              clk_i,
    input  logic              arst_n_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [MOD_W-1:0]  data_mod_i,
    input  logic              data_val_i,
    output logic              ready_o,
    output logic              ser_data_o,
    output logic              ser_data_val_o,
    output logic              busy_o,
    output logic              drop_o
);

    localparam logic [MOD_W:0] LenFull = (MOD_W + 1)'(DATA_W);
    localparam logic [MOD_W:0] MinLen  = (MOD_W + 1)'(MIN_LEN);

    typedef enum logic [0:0] {StIdle, StShift} state_e;

    state_e              r_state;
    logic [DATA_W-1:0]   r_shift;      // bits still to be sent, next one at the head
    logic [MOD_W:0]      r_cnt;        // bits remaining after the one on ser_data_o
    logic                r_ser_data;
    logic                r_ser_val;
    logic                r_drop;
    logic                r_pend_full;
    logic [DATA_W-1:0]   r_pend_data;
    logic [MOD_W:0]      r_pend_len;
    logic                r_rst_done;   // keeps ready_o low while in reset

    logic [MOD_W:0]      w_len;
    logic                w_ready;
    logic                w_present;
    logic                w_short;
    logic                w_accept;
    logic                w_drop;
    logic                w_last;
    logic                w_load_new;
    logic                w_load_pend;
    logic                w_load;
    logic                w_to_pend;
    logic [DATA_W-1:0]   w_ld_data;
    logic [MOD_W:0]      w_ld_len;

    function automatic logic head(input logic [DATA_W-1:0] d);
        return (MSB_FIRST != 0) ? d[DATA_W-1] : d[0];
    endfunction

    function automatic logic [DATA_W-1:0] advance(input logic [DATA_W-1:0] d);
        return (MSB_FIRST != 0) ? {d[DATA_W-2:0], 1'b0} : {1'b0, d[DATA_W-1:1]};
    endfunction

    assign w_len     = (data_mod_i == '0) ? LenFull : {1'b0, data_mod_i};
    assign w_ready   = r_rst_done && !r_pend_full;
    assign w_present = data_val_i && w_ready;
    assign w_short   = (w_len < MinLen);
    assign w_accept  = w_present && !w_short;
    assign w_drop    = w_present && w_short;

    // The shifter frees up at the edge that ends the current last bit.
    assign w_last      = (r_state == StShift) && (r_cnt == '0);
    assign w_load_new  = w_accept && ((r_state == StIdle) || w_last);
    assign w_to_pend   = w_accept && !w_load_new;
    // Pending and a fresh accept are exclusive: ready_o is low while pending is full.
    assign w_load_pend = w_last && r_pend_full;
    assign w_load      = w_load_new || w_load_pend;
    assign w_ld_data   = r_pend_full ? r_pend_data : data_i;
    assign w_ld_len    = r_pend_full ? r_pend_len : w_len;

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            r_state     <= StIdle;
            r_shift     <= '0;
            r_cnt       <= '0;
            r_ser_data  <= 1'b0;
            r_ser_val   <= 1'b0;
            r_drop      <= 1'b0;
            r_pend_full <= 1'b0;
            r_pend_data <= '0;
            r_pend_len  <= '0;
            r_rst_done  <= 1'b0;
        end else begin
            r_rst_done <= 1'b1;
            r_drop     <= w_drop;

            if (w_to_pend) begin
                r_pend_full <= 1'b1;
                r_pend_data <= data_i;
                r_pend_len  <= w_len;
            end else if (w_load_pend) begin
                r_pend_full <= 1'b0;
            end

            if (w_load) begin
                r_state    <= StShift;
                r_ser_val  <= 1'b1;
                r_ser_data <= head(w_ld_data);
                r_shift    <= advance(w_ld_data);
                r_cnt      <= w_ld_len - 1'b1;
            end else begin
                unique case (r_state)
                    StIdle: begin
                        r_ser_val  <= 1'b0;
                        r_ser_data <= 1'b0;
                    end
                    StShift: begin
                        if (w_last) begin
                            r_state    <= StIdle;
                            r_ser_val  <= 1'b0;
                            r_ser_data <= 1'b0;
                        end else begin
                            r_ser_data <= head(r_shift);
                            r_shift    <= advance(r_shift);
                            r_cnt      <= r_cnt - 1'b1;
                        end
                    end
                    default: begin
                        r_state    <= StIdle;
                        r_ser_val  <= 1'b0;
                        r_ser_data <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign ready_o        = w_ready;
    assign ser_data_o     = r_ser_data;
    assign ser_data_val_o = r_ser_val;
    assign drop_o         = r_drop;
    assign busy_o         = (r_state == StShift) || r_pend_full;

endmodule

// File: tb/tb_serializer_param.sv
// Directed bench for serializer_param: an MSB-first and an LSB-first instance
// share all stimulus; outputs are sampled on the falling clock edge.
module tb_serializer_param;

    logic        clk = 1'b0;
    logic        arst_n;
    logic [15:0] data;
    logic [3:0]  dmod;
    logic        dval;

    logic m_ready, m_ser, m_val, m_busy, m_drop;
    logic l_ready, l_ser, l_val, l_busy, l_drop;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    serializer_param #(.DATA_W(16), .MIN_LEN(3), .MSB_FIRST(1)) dut_m (
        .clk_i          (clk),
        .arst_n_i       (arst_n),
        .data_i         (data),
        .data_mod_i     (dmod),
        .data_val_i     (dval),
        .ready_o        (m_ready),
        .ser_data_o     (m_ser),
        .ser_data_val_o (m_val),
        .busy_o         (m_busy),
        .drop_o         (m_drop)
    );

    serializer_param #(.DATA_W(16), .MIN_LEN(3), .MSB_FIRST(0)) dut_l (
        .clk_i          (clk),
        .arst_n_i       (arst_n),
        .data_i         (data),
        .data_mod_i     (dmod),
        .data_val_i     (dval),
        .ready_o        (l_ready),
        .ser_data_o     (l_ser),
        .ser_data_val_o (l_val),
        .busy_o         (l_busy),
        .drop_o         (l_drop)
    );

    typedef struct {
        logic [15:0] data;
        logic [3:0]  mod;
        int          n;         // expected number of serial bits
        logic [31:0] bits;      // expected bits, first bit most significant, right-aligned
        logic        drop;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Present one word for a single cycle; returns at the falling edge after acceptance.
    task automatic send(input logic [15:0] d, input logic [3:0] m);
        data = d;
        dmod = m;
        dval = 1'b1;
        @(negedge clk);
        dval = 1'b0;
    endtask

    // Sample ncyc cycles starting at the current falling edge; history bit i = cycle i.
    task automatic collect(input int ncyc,
                           output logic [31:0] vh, output logic [31:0] rh,
                           output logic [31:0] bh, output logic [31:0] dh,
                           output logic [31:0] bits_m, output logic [31:0] bits_l,
                           output int n_l, output int bad);
        vh = '0; rh = '0; bh = '0; dh = '0; bits_m = '0; bits_l = '0; n_l = 0; bad = 0;
        for (int i = 0; i < ncyc; i++) begin
            vh[i] = m_val;
            rh[i] = m_ready;
            bh[i] = m_busy;
            dh[i] = m_drop;
            if (m_val) bits_m = {bits_m[30:0], m_ser};
            else if (m_ser) bad++;
            if (l_val) begin
                bits_l = {bits_l[30:0], l_ser};
                n_l++;
            end else if (l_ser) bad++;
            @(negedge clk);
        end
    endtask

    logic [31:0] vh, rh, bh, dh, bm, bl;
    int          nl, bad;

    initial begin
        vecs[0] = '{data: 16'hA5F0, mod: 4'd0,  n: 16, bits: 32'hA5F0, drop: 1'b0};
        vecs[1] = '{data: 16'hB800, mod: 4'd5,  n: 5,  bits: 32'h17,   drop: 1'b0};
        vecs[2] = '{data: 16'hFFFF, mod: 4'd2,  n: 0,  bits: 32'h0,    drop: 1'b1};
        vecs[3] = '{data: 16'h1234, mod: 4'd1,  n: 0,  bits: 32'h0,    drop: 1'b1};
        vecs[4] = '{data: 16'hFFFF, mod: 4'd3,  n: 3,  bits: 32'h7,    drop: 1'b0};
        vecs[5] = '{data: 16'h8001, mod: 4'd0,  n: 16, bits: 32'h8001, drop: 1'b0};
        vecs[6] = '{data: 16'h0000, mod: 4'd15, n: 15, bits: 32'h0,    drop: 1'b0};
        vecs[7] = '{data: 16'hC3C3, mod: 4'd8,  n: 8,  bits: 32'hC3,   drop: 1'b0};

        arst_n = 1'b0;
        data   = '0;
        dmod   = '0;
        dval   = 1'b0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("reset_outputs", {27'd0, m_ready, m_ser, m_val, m_busy, m_drop}, 32'h0);
        arst_n = 1'b1;
        @(negedge clk);
        check("ready_after_reset", {31'd0, m_ready}, 32'h1);

        // Single words from the table
        for (int v = 0; v < 8; v++) begin
            send(vecs[v].data, vecs[v].mod);
            collect(20, vh, rh, bh, dh, bm, bl, nl, bad);
            check($sformatf("v%0d_val", v), vh, (32'h1 << vecs[v].n) - 32'h1);
            check($sformatf("v%0d_bits", v), bm, vecs[v].bits);
            check($sformatf("v%0d_busy", v), bh, (32'h1 << vecs[v].n) - 32'h1);
            check($sformatf("v%0d_ready", v), rh, 32'h000F_FFFF);
            check($sformatf("v%0d_drop", v), dh, {31'd0, vecs[v].drop});
            check($sformatf("v%0d_zero_when_invalid", v), bad, 32'h0);
        end

        // Back-to-back: A goes straight in, B waits in the pending buffer
        data = 16'hF000;
        dmod = 4'd4;
        dval = 1'b1;
        @(negedge clk);
        data = 16'hA000;
        dmod = 4'd3;
        collect(1, vh, rh, bh, dh, bm, bl, nl, bad);
        dval = 1'b0;
        check("b2b_first_cycle", {29'd0, vh[0], rh[0], bm[0]}, 32'h7);
        collect(11, vh, rh, bh, dh, bm, bl, nl, bad);
        // cycles here are 1..11 of the back-to-back run
        check("b2b_val", vh, 32'h3F);
        check("b2b_bits", bm, 32'h3D);
        check("b2b_ready", rh & 32'h0F, 32'h08);
        check("b2b_busy", bh, 32'h3F);

        // Reset in the middle of a word
        send(16'hFFFF, 4'd0);
        collect(5, vh, rh, bh, dh, bm, bl, nl, bad);
        check("midword_before_reset", {30'd0, m_val, m_ser}, 32'h3);
        arst_n = 1'b0;
        #1;
        check("midword_reset_outputs", {27'd0, m_ready, m_ser, m_val, m_busy, m_drop}, 32'h0);
        @(negedge clk);
        @(negedge clk);
        arst_n = 1'b1;
        @(negedge clk);
        check("midword_ready_after", {31'd0, m_ready}, 32'h1);
        collect(20, vh, rh, bh, dh, bm, bl, nl, bad);
        check("midword_no_residual_val", vh, 32'h0);
        check("midword_no_residual_busy", bh, 32'h0);

        // LSB-first instance
        send(16'h000D, 4'd4);
        collect(20, vh, rh, bh, dh, bm, bl, nl, bad);
        check("lsb_count", nl, 32'd4);
        check("lsb_bits", bl, 32'hB);
        check("lsb_msb_inst_bits", bm, 32'h0);
        check("lsb_msb_inst_val", vh, 32'hF);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
